// File: rtl/hazard_detect_if.sv
// Hazard-detect interface: the ID-stage instruction and squash go in,
// and the stall controls come back out to the PC and IF_ID registers.
// master = the pipeline that drives IF_ID; slave = hazard_detect.
interface hazard_detect_if;
  logic [31:0] InstID;
  logic        Flush;
  logic        Hazard;
  logic        PCWrite;
  logic        IFIDWrite;
  logic [1:0]  StallState;

  modport master (
    output InstID, Flush,
    input  Hazard, PCWrite, IFIDWrite, StallState
  );

  modport slave (
    input  InstID, Flush,
    output Hazard, PCWrite, IFIDWrite, StallState
  );
endinterface

// File: rtl/hazard_detect.sv
// Hazard detection unit for a 5-stage MIPS pipeline.
// It decodes the instruction in ID and keeps a shadow copy of the ID_EX
// and EX_MEM destinations. It raises Hazard to freeze PC and IF_ID and to
// insert a bubble.
// Build option: define HAZARD_FWD_EN when the forwarding datapath exists.
// In that build only load-use stalls (1 cycle) remain. Without it, any RAW
// on EX (2 cycles) or MEM (1 cycle) stalls.
module hazard_detect (
  input  logic            clk,
  input  logic            rst_n,
  hazard_detect_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL1 = 2'b01,
    STALL2 = 2'b10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t     state;
  logic [4:0] ex_dst;
  logic       ex_load;
  logic [4:0] mem_dst;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = bus.InstID[31:26];
  assign rs     = bus.InstID[25:21];
  assign rt     = bus.InstID[20:16];
  assign rd     = bus.InstID[15:11];

  logic [4:0] id_dst;
  logic       use_rs;
  logic       use_rt;
  logic       id_is_load;

  // Decode which registers the ID instruction writes and reads.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    id_dst = 5'd0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        id_dst = rd;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_LW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        id_dst = rt;
        use_rs = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: begin
        id_dst = 5'd0;
        use_rs = 1'b0;
        use_rt = 1'b0;
      end
    endcase
  end

  assign id_is_load = (opcode == OP_LW);

  // A source equal to $0 never matches, because the shadow destination
  // for $0 or for a bubble is always zero and zero is screened out here.
  logic ex_match;
  logic raw_hazard;
  logic unused_bits;

  assign ex_match = (ex_dst != 5'd0) &&
                    ((use_rs && (rs == ex_dst)) || (use_rt && (rt == ex_dst)));

`ifdef HAZARD_FWD_EN
  // With forwarding, only a load in EX cannot be bypassed in time.
  // MEM is already covered by the forwarding paths.
  assign raw_hazard  = ex_load && ex_match;
  assign unused_bits = ^{mem_dst, bus.InstID[10:0]};
`else
  logic mem_match;
  assign mem_match = (mem_dst != 5'd0) &&
                     ((use_rs && (rs == mem_dst)) || (use_rt && (rt == mem_dst)));
  // Without forwarding, any producer still in EX or MEM blocks the read.
  // An EX match stalls twice; a MEM-only match stalls once.
  assign raw_hazard  = ex_match || mem_match;
  assign unused_bits = ^{ex_load, bus.InstID[10:0]};
`endif

  logic hazard;

  // A squashed instruction never stalls. STALL2 is the hard upper bound.
  // Reset forces the run state so the outputs are clean during reset.
  assign hazard = rst_n && !bus.Flush && (state != STALL2) && raw_hazard;

  assign bus.Hazard     = hazard;
  assign bus.PCWrite    = ~hazard;
  assign bus.IFIDWrite  = ~hazard;
  assign bus.StallState = state;

  // Shadow pipeline: track the destinations of the ID_EX and EX_MEM registers.
  // A bubble or a squash leaves an empty EX slot.
  // NOTE: async reset uses the sensitivity list form, and state updates use <= so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dst  <= 5'd0;
      ex_load <= 1'b0;
      mem_dst <= 5'd0;
    end else begin
      mem_dst <= ex_dst;
      if (hazard || bus.Flush) begin
        ex_dst  <= 5'd0;
        ex_load <= 1'b0;
      end else begin
        ex_dst  <= id_dst;
        ex_load <= id_is_load;
      end
    end
  end

  // Stall FSM: count consecutive stall cycles of the current ID instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= hazard ? STALL1 : RUN;
        STALL1:  state <= hazard ? STALL2 : RUN;
        STALL2:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_detect.sv
// Scoreboard bench for hazard_detect.
// A stimulus process issues instructions and pushes the expected outputs.
// A monitor pops them on the falling edge.
// The reference model treats the pipeline as a queue of in-flight
// (destination, is_load) slots and derives stalls from dependency rules.
module tb_hazard_detect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_detect_if bus ();

  hazard_detect dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] dst;
    logic       load;
  } slot_t;

  typedef struct {
    logic       hazard;
    logic [1:0] state;
    logic [4:0] ex_dst;
    logic       ex_load;
    logic [4:0] mem_dst;
  } exp_t;

  exp_t  sb[$];
  slot_t inflight[$];
  int    run_len;
  bit    last_hz;
  int    total_checks  = 0;
  int    passed_checks = 0;

  localparam logic [31:0] LW2_1     = 32'h8C220000; // lw  $2,0($1)
  localparam logic [31:0] ADD3_2_4  = 32'h00441820; // add $3,$2,$4
  localparam logic [31:0] ADD2_1_1  = 32'h00211020; // add $2,$1,$1
  localparam logic [31:0] SUB5_2_2  = 32'h00422822; // sub $5,$2,$2
  localparam logic [31:0] ADD7_8_9  = 32'h01093820; // add $7,$8,$9
  localparam logic [31:0] LW0_1     = 32'h8C200000; // lw  $0,0($1)
  localparam logic [31:0] ADD3_0_0  = 32'h00001820; // add $3,$0,$0
  localparam logic [31:0] BEQ2_3    = 32'h10430000; // beq $2,$3,0
  localparam logic [31:0] SW2_5     = 32'hACA20004; // sw  $2,4($5)
  localparam logic [31:0] NOP       = 32'h00000000;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
  endtask

  // Destination register written by an instruction. $0 means no write.
  function automatic logic [4:0] dest_of(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'h00) return i[15:11];
    if (op inside {6'h23, 6'h08, 6'h0C, 6'h0D, 6'h0A}) return i[20:16];
    return 5'd0;
  endfunction

  // True when the instruction reads register r. $0 is never a dependency.
  function automatic bit reads(input logic [31:0] i, input logic [4:0] r);
    logic [5:0] op;
    op = i[31:26];
    if (r == 5'd0) return 1'b0;
    if ((op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A}) &&
        (i[25:21] == r)) return 1'b1;
    if ((op inside {6'h00, 6'h2B, 6'h04}) && (i[20:16] == r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit depends(input logic [31:0] i);
`ifdef HAZARD_FWD_EN
    return inflight[0].load && reads(i, inflight[0].dst);
`else
    foreach (inflight[k]) if (reads(i, inflight[k].dst)) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic clear_model();
    slot_t bubble;
    bubble = '{dst: 5'd0, load: 1'b0};
    inflight.delete();
    inflight.push_back(bubble);
    inflight.push_back(bubble);
    run_len = 0;
  endtask

  // One clock cycle: drive inputs, predict the outputs, then advance the model.
  task automatic step(input logic [31:0] inst, input logic flush, input logic rst_val);
    exp_t  e;
    slot_t s;
    bit    hz;
    @(posedge clk);
    #1;
    bus.InstID = inst;
    bus.Flush  = flush;
    rst_n      = rst_val;
    if (!rst_val) clear_model();
    hz = rst_val && !flush && (run_len < 2) && depends(inst);
    e.hazard  = hz;
    e.state   = 2'(run_len);
    e.ex_dst  = inflight[0].dst;
    e.ex_load = inflight[0].load;
    e.mem_dst = inflight[1].dst;
    sb.push_back(e);
    if (rst_val) begin
      if (hz || flush) s = '{dst: 5'd0, load: 1'b0};
      else             s = '{dst: dest_of(inst), load: (inst[31:26] == 6'h23)};
      inflight.push_front(s);
      void'(inflight.pop_back());
      run_len = hz ? run_len + 1 : 0;
    end
    last_hz = hz;
  endtask

  // Present an instruction and keep it held in ID while the model predicts a stall.
  task automatic issue(input logic [31:0] inst, input logic flush);
    int n;
    step(inst, flush, 1'b1);
    n = 0;
    while (last_hz && n < 4) begin
      step(inst, 1'b0, 1'b1);
      n++;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [10];
    logic [31:0] i;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h0F};
    i = $urandom;
    i[31:26] = ops[$urandom_range(0, 9)];
    i[25:21] = 5'($urandom_range(0, 3));
    i[20:16] = 5'($urandom_range(0, 3));
    i[15:11] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // Monitor: compare every presented output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("Hazard",     {31'd0, bus.Hazard},     {31'd0, e.hazard});
        check("PCWrite",    {31'd0, bus.PCWrite},    {31'd0, ~e.hazard});
        check("IFIDWrite",  {31'd0, bus.IFIDWrite},  {31'd0, ~e.hazard});
        check("StallState", {30'd0, bus.StallState}, {30'd0, e.state});
        check("ExDst",      {27'd0, dut.ex_dst},     {27'd0, e.ex_dst});
        check("ExLoad",     {31'd0, dut.ex_load},    {31'd0, e.ex_load});
        check("MemDst",     {27'd0, dut.mem_dst},    {27'd0, e.mem_dst});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    bus.InstID = NOP;
    bus.Flush  = 1'b0;
    last_hz    = 1'b0;
    clear_model();

    // Reset holds clean outputs even with a dependent instruction in ID.
    step(ADD3_2_4, 1'b0, 1'b0);
    step(SUB5_2_2, 1'b0, 1'b0);

    // The first instruction after release sees no hazard.
    issue(ADD3_2_4, 1'b0);
    issue(NOP, 1'b0);
    issue(NOP, 1'b0);

    // Load-use.
    issue(LW2_1, 1'b0);
    issue(ADD3_2_4, 1'b0);
    issue(NOP, 1'b0);
    issue(NOP, 1'b0);

    // ALU RAW, then an independent instruction.
    issue(ADD2_1_1, 1'b0);
    issue(SUB5_2_2, 1'b0);
    issue(ADD7_8_9, 1'b0);
    issue(NOP, 1'b0);
    issue(NOP, 1'b0);

    // MEM-only dependency.
    issue(ADD2_1_1, 1'b0);
    issue(ADD7_8_9, 1'b0);
    issue(SUB5_2_2, 1'b0);
    issue(NOP, 1'b0);
    issue(NOP, 1'b0);

    // Register 0 never stalls.
    issue(LW0_1, 1'b0);
    issue(ADD3_0_0, 1'b0);
    issue(NOP, 1'b0);
    issue(NOP, 1'b0);

    // Flushed branch after a load.
    issue(LW2_1, 1'b0);
    issue(BEQ2_3, 1'b1);
    issue(NOP, 1'b0);
    issue(NOP, 1'b0);

    // Store reading rt.
    issue(LW2_1, 1'b0);
    issue(SW2_5, 1'b0);
    issue(NOP, 1'b0);
    issue(NOP, 1'b0);

    // Reset asserted in STALL1 aborts the stall at once.
    step(LW2_1, 1'b0, 1'b1);
    step(ADD3_2_4, 1'b0, 1'b1);
    step(ADD3_2_4, 1'b0, 1'b0);
    step(ADD3_2_4, 1'b0, 1'b0);
    step(ADD3_2_4, 1'b0, 1'b1);
    issue(NOP, 1'b0);

    // Random traffic. A stalled instruction stays held in IF_ID.
    held = rand_inst();
    for (int n = 0; n < 1500; n++) begin
      if (!last_hz) held = rand_inst();
      step(held, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
    end
    step(NOP, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total_checks++;
      $display("FAIL drain: %0d predictions left unconsumed, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
